// File: rtl/music_beat_sequencer.sv
// Song playback sequencer: steps a 1/4-beat index at a programmable tempo, selects one
// tone ROM output and registers it for the speaker divider. Supports play/pause/stop,
// song selection latched at start and a one-cycle end-of-song pulse.
// Build option: define MUSIC_SEQ_LOOP_EN to loop the song forever instead of stopping in
// DONE after the last beat.
module music_beat_sequencer #(
  parameter int unsigned NUM_SONGS      = 4,
  parameter int unsigned SEL_W          = 2,
  parameter int unsigned BEAT_W         = 8,
  parameter int unsigned TONE_W         = 32,
  parameter int unsigned TICKS_PER_BEAT = 12_500_000,
  parameter int unsigned SILENCE        = 20000
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          play,
  input  logic                          pause,
  input  logic                          stop,
  input  logic [SEL_W-1:0]              song_sel,
  input  logic [BEAT_W-1:0]             last_beat,
  input  logic [NUM_SONGS*TONE_W-1:0]   tone_bus,
  output logic [BEAT_W-1:0]             beat_num,
  output logic [TONE_W-1:0]             tone,
  output logic [SEL_W-1:0]              song_idx,
  output logic                          playing,
  output logic                          done
);

  localparam int unsigned       TICK_W       = $clog2(TICKS_PER_BEAT);
  localparam logic [TICK_W-1:0] TICK_LAST    = TICK_W'(TICKS_PER_BEAT - 1);
  localparam logic [TONE_W-1:0] SILENCE_TONE = TONE_W'(SILENCE);

  typedef enum logic [1:0] {StIdle, StPlay, StPause, StDone} state_e;

  state_e              state_q, state_d;
  logic [BEAT_W-1:0]   beat_q, beat_d;
  logic [TICK_W-1:0]   tick_q, tick_d;
  logic [SEL_W-1:0]    song_q, song_d;
  logic [TONE_W-1:0]   tone_q, tone_d;
  logic                done_q, done_d;
  logic [TONE_W-1:0]   sel_tone;
  logic [SEL_W-1:0]    song_start;

  // Out-of-range song numbers fall back to song 0.
  assign song_start = (32'(song_sel) >= NUM_SONGS) ? '0 : song_sel;

  // Pick the ROM word for the latched song.
  always_comb begin
    sel_tone = SILENCE_TONE;
    for (int unsigned k = 0; k < NUM_SONGS; k++) begin
      if (32'(song_q) == k) sel_tone = tone_bus[k*TONE_W +: TONE_W];
    end
  end

  // Next-state logic: command priority stop > pause > play.
  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    tick_d  = tick_q;
    song_d  = song_q;
    done_d  = 1'b0;
    unique case (state_q)
      StIdle, StDone: begin
        if (stop) begin
          state_d = StIdle;
          beat_d  = '0;
          tick_d  = '0;
        end else if (play) begin
          state_d = StPlay;
          song_d  = song_start;
          beat_d  = '0;
          tick_d  = '0;
        end
      end
      StPlay: begin
        if (stop) begin
          state_d = StIdle;
          beat_d  = '0;
          tick_d  = '0;
        end else if (pause) begin
          state_d = StPause;
        end else if (tick_q == TICK_LAST) begin
          tick_d = '0;
          if (beat_q == last_beat) begin
            done_d = 1'b1;
`ifdef MUSIC_SEQ_LOOP_EN
            beat_d = '0;
`else
            state_d = StDone;
`endif
          end else begin
            // Natural wrap at the top lets a lowered last_beat still be reached.
            beat_d = beat_q + 1'b1;
          end
        end else begin
          tick_d = tick_q + 1'b1;
        end
      end
      StPause: begin
        if (stop) begin
          state_d = StIdle;
          beat_d  = '0;
          tick_d  = '0;
        end else if (play && !pause) begin
          state_d = StPlay;
        end
      end
      default: state_d = StIdle;
    endcase
    // Tone follows the ROM only while playback continues; ROM output lags beat by a cycle.
    tone_d = (state_q == StPlay && state_d == StPlay) ? sel_tone : SILENCE_TONE;
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      beat_q  <= '0;
      tick_q  <= '0;
      song_q  <= '0;
      tone_q  <= SILENCE_TONE;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      tick_q  <= tick_d;
      song_q  <= song_d;
      tone_q  <= tone_d;
      done_q  <= done_d;
    end
  end

  assign beat_num = beat_q;
  assign tone     = tone_q;
  assign song_idx = song_q;
  assign playing  = (state_q == StPlay);
  assign done     = done_q;

endmodule

// File: tb/tb_music_beat_sequencer.sv
// Directed bench for music_beat_sequencer: 2 songs, 4 ticks per beat, last_beat = 3.
// ROM0 = beat*10+1000, ROM1 = beat*100+100.
module tb_music_beat_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        play = 1'b0, pause = 1'b0, stop = 1'b0;
  logic [1:0]  song_sel = 2'd0;
  logic [7:0]  last_beat = 8'd3;
  logic [63:0] tone_bus;
  logic [7:0]  beat_num;
  logic [31:0] tone;
  logic [1:0]  song_idx;
  logic        playing, done;

  int asserts = 0;
  int fails = 0;

  music_beat_sequencer #(
    .NUM_SONGS(2), .SEL_W(2), .BEAT_W(8), .TONE_W(32), .TICKS_PER_BEAT(4), .SILENCE(20000)
  ) dut (
    .clk(clk), .rst(rst), .play(play), .pause(pause), .stop(stop), .song_sel(song_sel),
    .last_beat(last_beat), .tone_bus(tone_bus), .beat_num(beat_num), .tone(tone),
    .song_idx(song_idx), .playing(playing), .done(done)
  );

  always #5 clk = ~clk;

  always_comb
    tone_bus = {32'(beat_num) * 32'd100 + 32'd100, 32'(beat_num) * 32'd10 + 32'd1000};

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_song(input logic [1:0] sel);
    song_sel = sel;
    play = 1'b1;
    step();
    play = 1'b0;
  endtask

  task automatic stop_song();
    stop = 1'b1;
    step();
    stop = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    for (int n = 0; n < 10; n++) begin
      step();
      asserts++;
      if (beat_num !== 8'd0 || tone !== 32'd20000 || playing !== 1'b0 || done !== 1'b0) begin
        fails++;
        $display("FAIL reset_idle cyc %0d: beat=%0d tone=%0d playing=%b done=%b, want 0/20000/0/0",
                 n, beat_num, tone, playing, done);
      end
    end
  endtask

  task automatic test_play_song();
    start_song(2'd1);
    asserts++;
    if (playing !== 1'b1 || song_idx !== 2'd1 || beat_num !== 8'd0 || tone !== 32'd20000) begin
      fails++;
      $display("FAIL play_start: playing=%b song_idx=%0d beat=%0d tone=%0d, want 1/1/0/20000",
               playing, song_idx, beat_num, tone);
    end
    for (int n = 1; n < 16; n++) begin
      step();
      asserts++;
      if (beat_num !== 8'(n / 4) || tone !== 32'(((n - 1) / 4) * 100 + 100) || done !== 1'b0) begin
        fails++;
        $display("FAIL play_seq cyc %0d: beat=%0d tone=%0d done=%b, want %0d/%0d/0",
                 n, beat_num, tone, done, n / 4, ((n - 1) / 4) * 100 + 100);
      end
    end
    step();
`ifdef MUSIC_SEQ_LOOP_EN
    asserts++;
    if (done !== 1'b1 || beat_num !== 8'd0 || playing !== 1'b1 || tone !== 32'd400) begin
      fails++;
      $display("FAIL song_end_loop: done=%b beat=%0d playing=%b tone=%0d, want 1/0/1/400",
               done, beat_num, playing, tone);
    end
    step();
    asserts++;
    if (done !== 1'b0 || beat_num !== 8'd0 || tone !== 32'd100 || playing !== 1'b1) begin
      fails++;
      $display("FAIL song_loop_next: done=%b beat=%0d tone=%0d playing=%b, want 0/0/100/1",
               done, beat_num, tone, playing);
    end
`else
    asserts++;
    if (done !== 1'b1 || beat_num !== 8'd3 || playing !== 1'b0 || tone !== 32'd20000) begin
      fails++;
      $display("FAIL song_end: done=%b beat=%0d playing=%b tone=%0d, want 1/3/0/20000",
               done, beat_num, playing, tone);
    end
    step();
    asserts++;
    if (done !== 1'b0 || beat_num !== 8'd3 || tone !== 32'd20000 || playing !== 1'b0) begin
      fails++;
      $display("FAIL song_done_hold: done=%b beat=%0d tone=%0d playing=%b, want 0/3/20000/0",
               done, beat_num, tone, playing);
    end
`endif
    stop_song();
    asserts++;
    if (playing !== 1'b0 || beat_num !== 8'd0) begin
      fails++;
      $display("FAIL stop_after_end: playing=%b beat=%0d, want 0/0", playing, beat_num);
    end
  endtask

  task automatic test_pause();
    start_song(2'd1);
    for (int n = 1; n < 10; n++) step();  // now beat 2, tick 1
    pause = 1'b1;
    for (int n = 0; n < 10; n++) begin
      step();
      asserts++;
      if (tone !== 32'd20000 || beat_num !== 8'd2 || playing !== 1'b0) begin
        fails++;
        $display("FAIL pause_hold cyc %0d: tone=%0d beat=%0d playing=%b, want 20000/2/0",
                 n, tone, beat_num, playing);
      end
    end
    pause = 1'b0;
    play = 1'b1;
    step();
    play = 1'b0;
    asserts++;
    if (playing !== 1'b1 || beat_num !== 8'd2 || tone !== 32'd20000) begin
      fails++;
      $display("FAIL pause_resume: playing=%b beat=%0d tone=%0d, want 1/2/20000",
               playing, beat_num, tone);
    end
    step();
    step();
    asserts++;
    if (beat_num !== 8'd2 || tone !== 32'd300) begin
      fails++;
      $display("FAIL pause_beat2_tail: beat=%0d tone=%0d, want 2/300", beat_num, tone);
    end
    step();
    asserts++;
    if (beat_num !== 8'd3) begin
      fails++;
      $display("FAIL pause_beat3: beat=%0d, want 3", beat_num);
    end
    stop_song();
  endtask

  task automatic test_all_cmds();
    start_song(2'd1);
    for (int n = 0; n < 5; n++) step();
    play = 1'b1;
    pause = 1'b1;
    stop = 1'b1;
    step();
    play = 1'b0;
    pause = 1'b0;
    stop = 1'b0;
    asserts++;
    if (playing !== 1'b0 || beat_num !== 8'd0 || tone !== 32'd20000) begin
      fails++;
      $display("FAIL all_cmds_stop: playing=%b beat=%0d tone=%0d, want 0/0/20000",
               playing, beat_num, tone);
    end
  endtask

  task automatic test_song_sel_latch();
    start_song(2'd1);
    song_sel = 2'd0;
    for (int n = 0; n < 6; n++) step();
    asserts++;
    if (song_idx !== 2'd1 || tone !== 32'd200) begin
      fails++;
      $display("FAIL sel_latch: song_idx=%0d tone=%0d, want 1/200", song_idx, tone);
    end
    stop_song();
  endtask

  task automatic test_clamp();
    start_song(2'd3);
    asserts++;
    if (song_idx !== 2'd0) begin
      fails++;
      $display("FAIL sel_clamp: song_idx=%0d, want 0", song_idx);
    end
    step();
    asserts++;
    if (tone !== 32'd1000) begin
      fails++;
      $display("FAIL clamp_tone: tone=%0d, want 1000", tone);
    end
    stop_song();
  endtask

  task automatic test_one_beat();
    last_beat = 8'd0;
    start_song(2'd1);
    for (int n = 1; n < 4; n++) step();
    asserts++;
    if (done !== 1'b0 || beat_num !== 8'd0) begin
      fails++;
      $display("FAIL one_beat_early: done=%b beat=%0d, want 0/0", done, beat_num);
    end
    step();
    asserts++;
`ifdef MUSIC_SEQ_LOOP_EN
    if (done !== 1'b1 || playing !== 1'b1 || beat_num !== 8'd0) begin
      fails++;
      $display("FAIL one_beat_end: done=%b playing=%b beat=%0d, want 1/1/0",
               done, playing, beat_num);
    end
`else
    if (done !== 1'b1 || playing !== 1'b0 || beat_num !== 8'd0) begin
      fails++;
      $display("FAIL one_beat_end: done=%b playing=%b beat=%0d, want 1/0/0",
               done, playing, beat_num);
    end
`endif
    last_beat = 8'd3;
    stop_song();
  endtask

  task automatic test_reset_mid();
    start_song(2'd1);
    for (int n = 1; n < 10; n++) step();
    rst = 1'b1;
    #1;
    asserts++;
    if (beat_num !== 8'd0 || tone !== 32'd20000 || playing !== 1'b0 || song_idx !== 2'd0) begin
      fails++;
      $display("FAIL reset_async: beat=%0d tone=%0d playing=%b song_idx=%0d, want 0/20000/0/0",
               beat_num, tone, playing, song_idx);
    end
    step();
    asserts++;
    if (beat_num !== 8'd0 || tone !== 32'd20000 || playing !== 1'b0 || done !== 1'b0) begin
      fails++;
      $display("FAIL reset_mid: beat=%0d tone=%0d playing=%b done=%b, want 0/20000/0/0",
               beat_num, tone, playing, done);
    end
    rst = 1'b0;
    step();
    asserts++;
    if (done !== 1'b0 || playing !== 1'b0) begin
      fails++;
      $display("FAIL reset_after: done=%b playing=%b, want 0/0", done, playing);
    end
  endtask

  initial begin
    test_reset();
    test_play_song();
    test_pause();
    test_all_cmds();
    test_song_sel_latch();
    test_clamp();
    test_one_beat();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
    $finish;
  end

endmodule
